// File: rtl/ir_pkg.sv
// ir_pkg: shared sizes, FSM state type and fixed-point
// saturation helper for the cabinet IR convolver.
package ir_pkg;
  localparam int N_TAPS    = 128;
  localparam int WIDTH     = 16;
  localparam int FRAC      = 15;
  localparam int IR_ADDR_W = $clog2(N_TAPS);
  localparam int PROD_W    = 2 * WIDTH;
  localparam int ACC_W     = PROD_W + IR_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } ir_state_e;

  // >>> FRAC (floor), then clamp to the WIDTH-bit signed range
  function automatic logic [WIDTH-1:0] sat_shift(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    s  = a >>> FRAC;
    hi = ACC_W'((1 << (WIDTH - 1)) - 1);
    lo = -hi - ACC_W'(1);
    if (s > hi)
      s = hi;
    else if (s < lo)
      s = lo;
    return s[WIDTH-1:0];
  endfunction
endpackage

// File: rtl/ir_history_ram.sv
// ir_history_ram: N_TAPS x WIDTH circular sample history.
// Ports: clk, rst_n, i_we/i_waddr/i_wdata write, i_raddr -> o_rdata (1-cycle).
module ir_history_ram
  import ir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [IR_ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [IR_ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [N_TAPS];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++)
        r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we)
        r_mem[i_waddr] <= i_wdata;
      // write-first so the newest sample is readable at once
      if (i_we && (i_waddr == i_raddr))
        r_rdata <= i_wdata;
      else
        r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ir_convolver.sv
// ir_convolver: 128-tap FIR, one time-shared MAC, saturated output.
// Ports: clk, rst_n, weights, in_valid/in_sample/in_ready, out_valid/out_sample.
module ir_convolver
  import ir_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_TAPS-1:0][WIDTH-1:0] weights,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_sample,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_sample
);

  ir_state_e                r_state;
  logic [IR_ADDR_W-1:0]     r_wr_ptr;
  logic [IR_ADDR_W-1:0]     r_k;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic [WIDTH-1:0]         r_out_sample;

  logic                     w_accept;
  logic [IR_ADDR_W-1:0]     w_raddr;
  logic [WIDTH-1:0]         w_rdata;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;

  assign w_accept = (r_state == IDLE) && in_valid;

  // read runs one tap ahead of r_k to hide the RAM latency
  assign w_raddr = (r_state == MAC)
                 ? r_wr_ptr - r_k - IR_ADDR_W'(1)
                 : r_wr_ptr;

  ir_history_ram u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_sample),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_prod = $signed(weights[r_k]) * $signed(w_rdata);
  assign w_acc_next = r_acc + ACC_W'(r_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_k          <= '0;
      r_prod       <= '0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= '0;
            r_prod  <= '0;
            r_k     <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_prod <= w_prod;
          r_acc  <= w_acc_next;
          r_k    <= r_k + IR_ADDR_W'(1);
          if (r_k == '1)
            r_state <= DRAIN;
        end
        DRAIN: begin
          r_acc        <= w_acc_next;
          r_wr_ptr     <= r_wr_ptr + IR_ADDR_W'(1);
          r_out_sample <= sat_shift(w_acc_next);
          r_out_valid  <= 1'b1;
          r_state      <= OUT;
        end
        OUT: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;

endmodule

// File: tb/tb_ir_convolver.sv
// tb_ir_convolver: random and directed stimulus vs a
// plain-arithmetic FIR reference model.
module tb_ir_convolver;

  logic               clk;
  logic               rst_n;
  logic [127:0][15:0] weights;
  logic               in_valid;
  logic [15:0]        in_sample;
  logic               in_ready;
  logic               out_valid;
  logic [15:0]        out_sample;

  int n_cmp;
  int n_bad;
  int hist_q[$];
  logic [127:0][15:0] imp_w;

  ir_convolver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .weights    (weights),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_sample (out_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] clamp16(input longint v);
    longint y;
    y = v;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y[15:0];
  endfunction

  // y[n] = sat((sum_k w[k]*x[n-k]) >>> 15); x older than 128 drop out
  function automatic logic [15:0] model_push(input logic [15:0] s);
    longint sum;
    hist_q.push_front(int'($signed(s)));
    if (hist_q.size() > 128)
      void'(hist_q.pop_back());
    sum = 0;
    foreach (hist_q[k])
      sum += longint'($signed(weights[k])) * longint'(hist_q[k]);
    return clamp16(sum >>> 15);
  endfunction

  task automatic send(input logic [15:0] s, output logic [15:0] got);
    int n;
    logic [15:0] exp;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check_eq("rdy_timeout", 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_sample = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp = model_push(s);
    n = 1;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    got = out_sample;
    if (!out_valid) begin
      check_eq("ov_timeout", 32'(out_valid), 1);
    end else begin
      check_eq("latency", 32'(n), 130);
      check_eq("out", 32'(out_sample), 32'(exp));
      check_eq("busy_rdy", 32'(in_ready), 0);
      @(posedge clk); #1;
      check_eq("ov_pulse", 32'(out_valid), 0);
      check_eq("rdy_back", 32'(in_ready), 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_rdy", 32'(in_ready), 1);
    check_eq("rst_ov", 32'(out_valid), 0);
    check_eq("rst_out", 32'(out_sample), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist_q.delete();
    @(posedge clk); #1;
    check_eq("post_rdy", 32'(in_ready), 1);
    check_eq("post_ov", 32'(out_valid), 0);
    check_eq("post_out", 32'(out_sample), 0);
  endtask

  task automatic run_impulse(input int n_out);
    logic [15:0] got;
    longint de;
    for (int j = 0; j < n_out; j++) begin
      send((j == 0) ? 16'h7FFF : 16'h0000, got);
      if (j < 128)
        de = (32767 * longint'($signed(imp_w[j]))) >>> 15;
      else
        de = 0;
      check_eq($sformatf("imp%0d", j), 32'(got), 32'(clamp16(de)));
    end
  endtask

  initial begin : main
    logic [15:0] got;
    int acc_t[$];
    logic [15:0] exp_q[$];
    int n_acc;
    int last_t;
    int seen;
    bit took;

    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    for (int k = 0; k < 128; k++)
      imp_w[k] = 16'($urandom);
    imp_w[0] = 16'h05C2;
    weights = imp_w;

    do_reset();
    send(16'h0000, got);
    check_eq("first_zero", 32'(got), 0);

    // impulse: 0x7FFF then 130 zeros, including the wrap
    do_reset();
    run_impulse(131);

    // random samples, moderate weights
    for (int k = 0; k < 128; k++)
      weights[k] = 16'($urandom_range(0, 8191) - 4096);
    for (int i = 0; i < 20; i++)
      send(16'($urandom), got);

    // saturation
    do_reset();
    for (int k = 0; k < 128; k++)
      weights[k] = 16'h7FFF;
    for (int i = 0; i < 4; i++) begin
      send(16'h7FFF, got);
      if (i >= 1) check_eq("sat_pos", 32'(got), 32'h7FFF);
    end
    for (int i = 0; i < 8; i++)
      send(16'h8000, got);
    check_eq("sat_neg", 32'(got), 32'h8000);

    // backpressure: in_valid held high, incrementing samples
    for (int k = 0; k < 128; k++)
      weights[k] = 16'($urandom_range(0, 8191) - 4096);
    n_acc     = 0;
    last_t    = 0;
    in_valid  = 1'b1;
    in_sample = 16'h0100;
    for (int cyc = 0; cyc < 5 * 131 + 140; cyc++) begin
      if (out_valid) begin
        if (acc_t.size() == 0) begin
          check_eq("bp_spurious", 32'(out_valid), 0);
        end else begin
          check_eq("bp_lat", 32'(cyc - acc_t.pop_front()), 130);
          check_eq("bp_out", 32'(out_sample), 32'(exp_q.pop_front()));
        end
      end
      took = 1'b0;
      if (in_ready && in_valid) begin
        if (n_acc > 0)
          check_eq("bp_gap", 32'(cyc - last_t), 131);
        last_t = cyc;
        acc_t.push_back(cyc);
        exp_q.push_back(model_push(in_sample));
        n_acc++;
        took = 1'b1;
      end
      @(posedge clk); #1;
      if (took) begin
        in_sample = in_sample + 16'd1;
        if (n_acc == 5) in_valid = 1'b0;
      end
    end
    check_eq("bp_pending", 32'(acc_t.size()), 0);
    check_eq("bp_count", 32'(n_acc), 5);

    // reset in the middle of MAC
    weights = imp_w;
    in_valid  = 1'b1;
    in_sample = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (49) begin
      @(posedge clk); #1;
    end
    do_reset();
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("rst_no_ov", 32'(seen), 0);
    run_impulse(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
